// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the bus master interface.
// Holds the FSM state encoding, the active-low enable levels used on the bus
// control lines, the rw direction encoding and the default bus widths.
package bus_master_if_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StReq    = 2'd1,
      StAccess = 2'd2,
      StWait   = 2'd3
   } state_e;

   // Bus control lines are active-low
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   localparam int unsigned DEF_ADDR_W = 30;
   localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/bus_master_if_timer.sv
// WAIT-state timeout counter for bus_master_if.
// Only instantiated when BUS_MASTER_IF_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   wait_cyc  - high while the master sits in WAIT; low clears the count
//   expired   - high in the WAIT cycle in which the count reaches TIMEOUT_CYC
module bus_master_if_timer #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic wait_cyc,
   output logic expired
);

   localparam int unsigned CntW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
   // cnt_q holds completed WAIT cycles, so the TIMEOUT_CYC-th one sees Limit
   localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYC - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (wait_cyc) begin
         cnt_d = (cnt_q == Limit) ? cnt_q : cnt_q + CntW'(1);
      end
   end

   assign expired = wait_cyc && (cnt_q == Limit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bus_master_if.sv
// Master-side bus interface unit: turns a single core access into the shared
// bus handshake (request, grant, address strobe, wait for ready). One access
// outstanding at most; completion reported by core_ack, abort by core_err.
// Optional: define BUS_MASTER_IF_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   core_req/rw/addr/wr_data  - core access request (accepted when not busy)
//   core_busy/ack/err/rd_data - core status, completion pulses, read data
//   bus_req_/bus_grnt_        - arbiter request/grant (active-low)
//   bus_addr/as_/rw/wr_data   - access drive towards slaves
//   bus_rd_data/bus_rdy_      - muxed slave response
module bus_master_if
   import bus_master_if_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_rw,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wr_data,
   output logic              core_busy,
   output logic              core_ack,
   output logic              core_err,
   output logic [DATA_W-1:0] core_rd_data,
   output logic              bus_req_,
   input  logic              bus_grnt_,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_
);

   state_e            state_q, state_d;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              done, abort, timeout_hit, drive;

   logic              bus_req_q, bus_req_d;
   logic              bus_as_q, bus_as_d;
   logic              bus_rw_q, bus_rw_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
   logic              core_ack_q, core_err_q;
   logic [DATA_W-1:0] rd_data_q;

`ifdef BUS_MASTER_IF_TIMEOUT_EN
   bus_master_if_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .wait_cyc(state_q == StWait),
      .expired (timeout_hit)
   );
`else
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT_CYC != 0);
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         StIdle: if (core_req) state_d = StReq;
         StReq:  if (bus_grnt_ == ENABLE_) state_d = StAccess;
         StAccess, StWait: begin
            // Ready wins over a simultaneous grant loss or timeout
            if (bus_rdy_ == ENABLE_) begin
               done    = 1'b1;
               state_d = StIdle;
            end else if ((bus_grnt_ == DISABLE_) || timeout_hit) begin
               abort   = 1'b1;
               state_d = StIdle;
            end else begin
               state_d = StWait;
            end
         end
         default: state_d = StIdle;
      endcase

      // Bus outputs are registered, so encode them from the next state
      drive         = (state_d == StAccess) || (state_d == StWait);
      bus_req_d     = (state_d == StIdle) ? DISABLE_ : ENABLE_;
      bus_as_d      = (state_d == StAccess) ? ENABLE_ : DISABLE_;
      bus_rw_d      = drive ? rw_q : WRITE;
      bus_addr_d    = drive ? addr_q : '0;
      bus_wr_data_d = drive ? wr_data_q : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         rw_q          <= WRITE;
         addr_q        <= '0;
         wr_data_q     <= '0;
         bus_req_q     <= DISABLE_;
         bus_as_q      <= DISABLE_;
         bus_rw_q      <= WRITE;
         bus_addr_q    <= '0;
         bus_wr_data_q <= '0;
         core_ack_q    <= 1'b0;
         core_err_q    <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == StIdle) && core_req) begin
            rw_q      <= core_rw;
            addr_q    <= core_addr;
            wr_data_q <= core_wr_data;
         end
         bus_req_q     <= bus_req_d;
         bus_as_q      <= bus_as_d;
         bus_rw_q      <= bus_rw_d;
         bus_addr_q    <= bus_addr_d;
         bus_wr_data_q <= bus_wr_data_d;
         core_ack_q    <= done;
         core_err_q    <= abort;
         if (done && (rw_q == READ)) begin
            rd_data_q <= bus_rd_data;
         end
      end
   end

   assign core_busy    = (state_q != StIdle);
   assign core_ack     = core_ack_q;
   assign core_err     = core_err_q;
   assign core_rd_data = rd_data_q;
   assign bus_req_     = bus_req_q;
   assign bus_as_      = bus_as_q;
   assign bus_rw       = bus_rw_q;
   assign bus_addr     = bus_addr_q;
   assign bus_wr_data  = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: the bench plays arbiter and slave,
// a reference model predicts each access outcome into a scoreboard queue, and
// a monitor pops and compares on every core_ack/core_err pulse.
module tb_bus_master_if;

   localparam int TIMEOUT = 4;
`ifdef BUS_MASTER_IF_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct packed {
      logic        err;
      logic [31:0] rd;
   } exp_t;

   logic        clk, rst;
   logic        core_req, core_rw, core_busy, core_ack, core_err;
   logic [29:0] core_addr, bus_addr;
   logic [31:0] core_wr_data, core_rd_data, bus_wr_data, bus_rd_data;
   logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;

   int          errors = 0;
   int          checks = 0;
   exp_t        sb_q[$];
   logic [31:0] last_rd = '0;

   bus_master_if #(
      .ADDR_W     (30),
      .DATA_W     (32),
      .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .core_req    (core_req),
      .core_rw     (core_rw),
      .core_addr   (core_addr),
      .core_wr_data(core_wr_data),
      .core_busy   (core_busy),
      .core_ack    (core_ack),
      .core_err    (core_err),
      .core_rd_data(core_rd_data),
      .bus_req_    (bus_req_),
      .bus_grnt_   (bus_grnt_),
      .bus_addr    (bus_addr),
      .bus_as_     (bus_as_),
      .bus_rw      (bus_rw),
      .bus_wr_data (bus_wr_data),
      .bus_rd_data (bus_rd_data),
      .bus_rdy_    (bus_rdy_)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Outcome of one access from the protocol rules: the first of ready,
   // grant loss (strictly before ready) or timeout ends it.
   function automatic void predict(input bit rw, input logic [31:0] rd, input int waits,
                                   input int drop_at, output exp_t e, output int end_idx);
      end_idx = waits;
      e.err   = 1'b0;
      if (drop_at >= 0 && drop_at < waits) begin
         end_idx = drop_at;
         e.err   = 1'b1;
      end
      if (TO_EN && TIMEOUT < end_idx) begin
         end_idx = TIMEOUT;
         e.err   = 1'b1;
      end
      if (!e.err && rw) last_rd = rd;
      e.rd = last_rd;
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req_n"}, bus_req_, 1);
      chk({tag, "_as_n"}, bus_as_, 1);
      chk({tag, "_addr"}, bus_addr, 0);
      chk({tag, "_rw"}, bus_rw, 0);
      chk({tag, "_wr_data"}, bus_wr_data, 0);
      chk({tag, "_busy"}, core_busy, 0);
      chk({tag, "_ack"}, core_ack, 0);
      chk({tag, "_err"}, core_err, 0);
      chk({tag, "_rd_data"}, core_rd_data, 0);
   endtask

   // Called just after a negedge with the DUT idle; returns just after the
   // negedge of the IDLE cycle that follows completion.
   task automatic run_txn(input bit rw, input logic [29:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int gdel, input int waits,
                          input int drop_at);
      exp_t e;
      int   end_idx;
      predict(rw, rd, waits, drop_at, e, end_idx);
      sb_q.push_back(e);
      core_req     = 1'b1;
      core_rw      = rw;
      core_addr    = addr;
      core_wr_data = wd;
      @(posedge clk);
      for (int g = 0; g <= gdel; g++) begin
         @(negedge clk);
         chk("reqph_req_n", bus_req_, 0);
         chk("reqph_as_n", bus_as_, 1);
         chk("reqph_busy", core_busy, 1);
         // Busy: requests and ready must be ignored here
         core_req     = 1'($urandom_range(0, 1));
         core_rw      = 1'($urandom_range(0, 1));
         core_addr    = 30'($urandom);
         core_wr_data = $urandom;
         bus_rdy_     = 1'($urandom_range(0, 1));
         bus_grnt_    = (g == gdel) ? 1'b0 : 1'b1;
         @(posedge clk);
      end
      for (int i = 0; i <= end_idx; i++) begin
         @(negedge clk);
         chk("acc_req_n", bus_req_, 0);
         chk("acc_as_n", bus_as_, (i == 0) ? 1'b0 : 1'b1);
         chk("acc_addr", bus_addr, addr);
         chk("acc_rw", bus_rw, rw);
         chk("acc_wr_data", bus_wr_data, wd);
         chk("acc_busy", core_busy, 1);
         chk("acc_no_pulse", {core_ack, core_err}, 0);
         core_req    = 1'b0;
         bus_rdy_    = (i == waits) ? 1'b0 : 1'b1;
         bus_grnt_   = (i == drop_at) ? 1'b1 : 1'b0;
         bus_rd_data = (i == waits) ? rd : $urandom;
         @(posedge clk);
      end
      #1;
      bus_rdy_    = 1'b1;
      bus_grnt_   = 1'b1;
      bus_rd_data = $urandom;
      @(negedge clk);
      chk("end_ack", core_ack, !e.err);
      chk("end_err", core_err, e.err);
      chk("end_busy", core_busy, 0);
      chk("end_req_n", bus_req_, 1);
      chk("end_as_n", bus_as_, 1);
      chk("end_addr", bus_addr, 0);
      chk("end_wr_data", bus_wr_data, 0);
   endtask

   always @(negedge clk) begin
      if (!rst && (core_ack || core_err)) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", {core_ack, core_err}, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_err", core_err, e.err);
            chk("sb_ack", core_ack, !e.err);
            chk("sb_rd_data", core_rd_data, e.rd);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      core_req     = 1'b0;
      core_rw      = 1'b0;
      core_addr    = '0;
      core_wr_data = '0;
      bus_grnt_    = 1'b1;
      bus_rdy_     = 1'b1;
      bus_rd_data  = '0;
      #3;
      check_reset_vals("rst0");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Zero-wait read, best-case latency
      run_txn(1'b1, 30'h0000100, 32'h0, 32'hDEADBEEF, 0, 0, -1);
      repeat (3) begin
         @(negedge clk);
         chk("rd_hold", core_rd_data, last_rd);
      end

      // Write with three wait states, back to back with a read
      run_txn(1'b0, 30'h3FFFFFFF, 32'h12345678, $urandom, 0, 3, -1);
      run_txn(1'b1, 30'h0000055, 32'h0, 32'hA5A5_0F0F, 0, 1, -1);

      // Grant withheld ten cycles
      run_txn(1'b1, 30'h1234567, 32'h0, 32'hCAFE_F00D, 10, 0, -1);

      // Grant loss in WAIT, then grant loss coinciding with ready
      run_txn(1'b1, 30'h0000200, 32'h0, 32'h1111_2222, 0, 3, 2);
      run_txn(1'b1, 30'h0000204, 32'h0, 32'h3333_4444, 0, 2, 2);
      run_txn(1'b0, 30'h0000208, 32'hBEEF, 32'h0, 1, 2, 0);

      // Asynchronous reset mid-WAIT
      core_req     = 1'b1;
      core_rw      = 1'b1;
      core_addr    = 30'h00ABCDE;
      core_wr_data = '0;
      bus_grnt_    = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      core_req = 1'b0;
      chk("midwait_busy", core_busy, 1);
      chk("midwait_as_n", bus_as_, 1);
      chk("midwait_req_n", bus_req_, 0);
      #1;
      rst = 1'b1;
      #1;
      check_reset_vals("rst_mid");
      last_rd = '0;
      sb_q.delete();
      bus_grnt_ = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_quiet", {core_ack, core_err, core_busy}, 0);
      end
      run_txn(1'b1, 30'h0000300, 32'h0, 32'h5555_AAAA, 1, 1, -1);

      // Ready never comes: timeout (if enabled) or a very long WAIT
      run_txn(1'b1, 30'h0000400, 32'h0, 32'h7777_8888, 0, 1000, -1);

      // Randomized accesses
      for (int n = 0; n < 40; n++) begin
         bit          rw;
         int          gdel, waits, drop;
         rw    = 1'($urandom_range(0, 1));
         gdel  = int'($urandom_range(0, 3));
         waits = int'($urandom_range(0, 5));
         drop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, waits)) : -1;
         run_txn(rw, 30'($urandom), $urandom, $urandom, gdel, waits, drop);
         repeat (int'($urandom_range(0, 2))) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("sb_drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Master-side bus interface unit. Turns a single-access core request into the shared-bus master protocol: request, grant, address strobe, then wait for ready.
- One instance sits between each bus master (CPU fetch, CPU data, DMA) and one m*_ port group of the bus top.
- Holds at most one outstanding access. Latches the request, reports busy and completion to the core.

Parameters:
- ADDR_W, 30, word-address width (matches WordAddrBus).
- DATA_W, 32, data width (matches WordDataBus).
- TIMEOUT_CYC, 255, WAIT-state cycle limit. Used only with the optional feature; must be at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- core_req  in  1  access request; accepted when core_busy=0
- core_rw  in  1  1=read, 0=write (same encoding as bus rw)
- core_addr  in  ADDR_W  word address
- core_wr_data  in  DATA_W  write data
- core_busy  out  1  access in progress; new requests ignored
- core_ack  out  1  one-cycle completion pulse
- core_err  out  1  one-cycle abort pulse; never asserted together with core_ack
- core_rd_data  out  DATA_W  read data, valid from core_ack, held until the next completion
- bus_req_  out  1  bus request, active-low
- bus_grnt_  in  1  bus grant, active-low
- bus_addr  out  ADDR_W  access address
- bus_as_  out  1  address strobe, active-low
- bus_rw  out  1  access direction
- bus_wr_data  out  DATA_W  write data
- bus_rd_data  in  DATA_W  muxed slave read data
- bus_rdy_  in  1  muxed slave ready, active-low

Behaviour:
- Reset (asynchronous, immediate, also mid-access):
  - state=IDLE
  - bus_req_=1, bus_as_=1; bus_addr, bus_rw, bus_wr_data = 0
  - core_busy=0, core_ack=0, core_err=0, core_rd_data=0
  - Any in-flight access is dropped with no ack and no err.
- FSM states IDLE, REQ, ACCESS, WAIT. State is registered; bus outputs are registered and encoded per state.
- IDLE:
  - core_req=1 → latch rw/addr/wr_data, go to REQ.
  - core_busy = (state != IDLE).
- REQ: bus_req_=0. bus_grnt_=0 → ACCESS; otherwise stay in REQ (no timeout).
- ACCESS (exactly one cycle):
  - bus_req_=0, bus_as_=0; latched addr/rw/wr_data driven.
  - bus_rdy_=0 → complete; else → WAIT.
- WAIT:
  - bus_req_=0, bus_as_=1; addr/rw/wr_data still driven.
  - bus_rdy_=0 → complete.
- Complete:
  - On reads, register bus_rd_data into core_rd_data.
  - core_ack=1 for the next cycle. go to IDLE with bus_req_=1, bus_as_=1, bus data outputs zeroed.
- Grant loss (bus_grnt_=1 while in ACCESS or WAIT, with no bus_rdy_=0 in the same cycle): abort, core_err pulse, go to IDLE, no retry. Writes are never re-issued.
- bus_rdy_ is ignored outside ACCESS/WAIT. bus_grnt_ is ignored in IDLE.
- Simultaneous rdy_=0 and grnt_=1 in ACCESS/WAIT → complete (rdy_ wins).
- Back-to-back accesses: a new request is accepted in the IDLE cycle after completion. The bus is released for at least one cycle between accesses.
- Best-case latency:
  - core_req sampled at edge 0 → REQ in cycle 1.
  - Grant sampled at edge 1 → ACCESS in cycle 2.
  - Zero-wait rdy_ → core_ack high in cycle 3.

Optional Feature:
- BUS_MASTER_IF_TIMEOUT_EN defined:
  - An 8+ bit counter is cleared on entry to ACCESS and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYC without rdy_ → core_err pulse, go to IDLE, bus released.
  - rdy_=0 in the expiry cycle → normal completion.
- Undefined: no counter; WAIT may last indefinitely. core_err arises only from grant loss.

Decomposition:
- Shared bus package/header holds:
  - state encodings (IDLE=2'd0, REQ=2'd1, ACCESS=2'd2, WAIT=2'd3)
  - ENABLE_/DISABLE_ active-low constants
  - READ/WRITE rw encodings
  - ADDR_W/DATA_W defaults
- Optional sub-module bus_master_if_timer (timeout counter), instantiated only under BUS_MASTER_IF_TIMEOUT_EN. Everything else stays flat.

Test Plan:
1. Zero-wait read: core_req with addr=0x0000100 and rw=1; grant one cycle after req_; rdy_=0 in ACCESS with rd_data=0xDEADBEEF → as_ low exactly 1 cycle, core_ack in cycle 3, core_rd_data=0xDEADBEEF held afterwards.
2. Write with 3 wait states: rw=0, addr=0x3FFFFFFF, wr_data=0x12345678; rdy_=0 on the 3rd WAIT cycle → bus_wr_data stable through ACCESS+WAIT, single core_ack, req_ high the cycle after completion, core_rd_data unchanged.
3. Delayed grant: grant withheld 10 cycles → req_ low for all 10 cycles, as_ high, core_busy=1, and core_req toggling during busy is ignored.
4. Grant loss in WAIT: drop grnt_ with rdy_=1 → core_err single pulse, no core_ack, IDLE next cycle. Repeat with rdy_=0 in the same cycle → core_ack, no err.
5. Async reset asserted mid-WAIT → all outputs reach reset values before the next clk edge, no ack or err after release, and a new request completes normally.
6. With BUS_MASTER_IF_TIMEOUT_EN and TIMEOUT_CYC=4, rdy_ never asserted → core_err after 4 WAIT cycles, bus released. Without the macro → still in WAIT after 1000 cycles.
